// File: rtl/hlsm_chain_accum_if.sv
`default_nettype none
// ============================================================================
// Module   : hlsm_chain_accum_if
// Brief    : Start/operand/result bundle for hlsm_chain_accum.
// Revision : 1.0
// ============================================================================
interface hlsm_chain_accum_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 34
);
  logic                       start;
  logic [NUM_OPS*WIDTH-1:0]   ops;
  logic                       done;
  logic                       busy;
  logic                       ovf;
  logic [WIDTH-1:0]           result;

  modport master (output start, ops, input done, busy, ovf, result);
  modport slave  (input start, ops, output done, busy, ovf, result);
endinterface
`default_nettype wire

// File: rtl/hlsm_chain_accum.sv
`default_nettype none
// ============================================================================
// Module   : hlsm_chain_accum
// Brief    : Snapshots NUM_OPS operands and returns sum(op) + op[0] + op[1].
//            Define HLSM_SATURATE_EN to clamp every add on carry-out.
// Revision : 1.0
// ============================================================================
module hlsm_chain_accum #(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 34
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  hlsm_chain_accum_if.slave    bus
);
  localparam int SEL_W = $clog2(NUM_OPS);
  localparam int IDX_W = SEL_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_OPS - 1);
  localparam logic [IDX_W-1:0] FIRST_ACC = IDX_W'(2);

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_LOAD  = 3'd1,
    S_ACC   = 3'd2,
    S_FIX   = 3'd3,
    S_FINAL = 3'd4
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_snap [NUM_OPS];
  logic [WIDTH-1:0]   r_t1;
  logic [WIDTH-1:0]   r_acc;
  logic [IDX_W-1:0]   r_idx;
  logic               r_done;
  logic               r_busy;
  logic               r_ovf;
  logic [WIDTH-1:0]   r_result;

  logic [WIDTH:0]     w_t1_sum;
  logic [WIDTH:0]     w_acc_sum;
  logic [WIDTH:0]     w_fix_sum;
  logic [SEL_W-1:0]   w_sel;

  // MSB of the return value is the carry-out; the low bits wrap or clamp.
  function automatic logic [WIDTH:0] add_op(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef HLSM_SATURATE_EN
    if (s[WIDTH]) s[WIDTH-1:0] = '1;
`else
    s = s;
`endif
    return s;
  endfunction

  assign w_sel     = r_idx[SEL_W-1:0];
  assign w_t1_sum  = add_op(r_snap[0], r_snap[1]);
  assign w_acc_sum = add_op(r_acc, r_snap[w_sel]);
  assign w_fix_sum = add_op(r_acc, r_t1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_WAIT;
      r_t1     <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= '0;
      for (int k = 0; k < NUM_OPS; k++) r_snap[k] <= '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          r_done <= 1'b0;
          if (bus.start) begin
            for (int k = 0; k < NUM_OPS; k++) r_snap[k] <= bus.ops[k*WIDTH +: WIDTH];
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_t1  <= w_t1_sum[WIDTH-1:0];
          r_acc <= w_t1_sum[WIDTH-1:0];
          r_ovf <= r_ovf | w_t1_sum[WIDTH];
          r_idx <= FIRST_ACC;
          r_state <= (NUM_OPS == 2) ? S_FIX : S_ACC;
        end
        S_ACC: begin
          r_acc <= w_acc_sum[WIDTH-1:0];
          r_ovf <= r_ovf | w_acc_sum[WIDTH];
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= w_fix_sum[WIDTH-1:0];
          r_ovf    <= r_ovf | w_fix_sum[WIDTH];
          r_state  <= S_FINAL;
        end
        S_FINAL: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_WAIT;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_WAIT;
        end
      endcase
    end
  end

  assign bus.done   = r_done;
  assign bus.busy   = r_busy;
  assign bus.ovf    = r_ovf;
  assign bus.result = r_result;
endmodule
`default_nettype wire

// File: tb/tb_hlsm_chain_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_hlsm_chain_accum
// Brief    : Self-checking bench: vector table, random runs vs. model, corner sequences.
// Revision : 1.0
// ============================================================================
module tb_hlsm_chain_accum;
  localparam int W  = 32;
  localparam int N  = 34;
  localparam int W1 = 8;
  localparam int N1 = 2;
`ifdef HLSM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hlsm_chain_accum_if #(.WIDTH(W),  .NUM_OPS(N))  b0 ();
  hlsm_chain_accum_if #(.WIDTH(W1), .NUM_OPS(N1)) b1 ();

  hlsm_chain_accum #(.WIDTH(W),  .NUM_OPS(N))  dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  hlsm_chain_accum #(.WIDTH(W1), .NUM_OPS(N1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
  endtask

  // Reference: the result is the plain sum plus op0+op1 (mod 2^W); overflow and
  // saturation follow the chain of adds t1, acc+=op[k], acc+t1.
  function automatic void model(input logic [N*W-1:0] o,
                                output logic [W-1:0] res, output logic ovf);
    longint unsigned lim, t1, acc, sum;
    lim = 64'd1 << W;
    ovf = 1'b0;
    sum = 0;
    for (int k = 0; k < N; k++) sum += o[k*W +: W];
    sum += o[0 +: W];
    sum += o[W +: W];
    t1 = longint'(o[0 +: W]) + longint'(o[W +: W]);
    if (t1 >= lim) begin ovf = 1'b1; t1 = SAT ? lim - 1 : t1 - lim; end
    acc = t1;
    for (int k = 2; k < N; k++) begin
      acc += o[k*W +: W];
      if (acc >= lim) begin ovf = 1'b1; acc = SAT ? lim - 1 : acc - lim; end
    end
    acc += t1;
    if (acc >= lim) begin ovf = 1'b1; acc = SAT ? lim - 1 : acc - lim; end
    res = SAT ? W'(acc) : W'(sum % lim);
  endfunction

  function automatic logic [N*W-1:0] fill(input logic [W-1:0] o0, input logic [W-1:0] o1,
                                          input logic [W-1:0] rest);
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = (k == 0) ? o0 : (k == 1) ? o1 : rest;
    return v;
  endfunction

  // One full run on the 32x34 instance; sample n is taken after edge E_n.
  task automatic run0(input logic [N*W-1:0] ops_in, input logic [W-1:0] exp_res,
                      input logic exp_ovf, input string tag, input bit scramble);
    int n;
    @(negedge clk);
    b0.ops   = ops_in;
    b0.start = 1'b1;
    @(negedge clk);
    n = 0;
    b0.start = 1'b0;
    if (scramble) b0.ops = fill(32'd5, 32'd5, 32'd5);
    chk({tag, "_busy_e0"}, 64'(b0.busy), 64'd1);
    chk({tag, "_ovf_clr"}, 64'(b0.ovf), 64'd0);
    while (!b0.done && n < 60) begin
      @(negedge clk);
      n++;
      if (n == N) chk({tag, "_result_at_write"}, 64'(b0.result), 64'(exp_res));
    end
    chk({tag, "_done_latency"}, 64'(n), 64'(N + 1));
    chk({tag, "_result"}, 64'(b0.result), 64'(exp_res));
    chk({tag, "_ovf"}, 64'(b0.ovf), 64'(exp_ovf));
    chk({tag, "_busy_final"}, 64'(b0.busy), 64'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(b0.done), 64'd0);
  endtask

  typedef struct {
    logic [W-1:0] op0;
    logic [W-1:0] op1;
    logic [W-1:0] rest;
    logic [W-1:0] exp_res;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [W-1:0]   mres;
    logic           movf;
    logic [N*W-1:0] rops;
    int             dn;
    int             done_at [$];

    vecs[0] = '{32'd1,          32'd1, 32'd1,          32'd36,                               1'b0};
    vecs[1] = '{32'hFFFF_FFFF,  32'd2, 32'd0,          SAT ? 32'hFFFF_FFFF : 32'd2,          1'b1};
    vecs[2] = '{32'd0,          32'd0, 32'd0,          32'd0,                                1'b0};
    vecs[3] = '{32'd10,         32'd20, 32'd3,         32'd156,                              1'b0};
    vecs[4] = '{32'h8000_0000,  32'd0, 32'd0,          SAT ? 32'hFFFF_FFFF : 32'd0,          1'b1};
    vecs[5] = '{32'd0,          32'd0, 32'h0800_0000,  SAT ? 32'hFFFF_FFFF : 32'd0,          1'b1};

    b0.start = 1'b0; b0.ops = '0;
    b1.start = 1'b0; b1.ops = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   64'(b0.busy),   64'd0);
    chk("rst_done",   64'(b0.done),   64'd0);
    chk("rst_ovf",    64'(b0.ovf),    64'd0);
    chk("rst_result", 64'(b0.result), 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i])
      run0(fill(vecs[i].op0, vecs[i].op1, vecs[i].rest), vecs[i].exp_res, vecs[i].exp_ovf,
           $sformatf("vec%0d", i), 1'b0);

    // Snapshot must isolate the run from later operand changes.
    run0(fill(32'd1, 32'd1, 32'd1), 32'd36, 1'b0, "snapshot", 1'b1);

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < N; k++) begin
        case (r % 3)
          0:       rops[k*W +: W] = $urandom;
          1:       rops[k*W +: W] = $urandom_range(0, 1000);
          default: rops[k*W +: W] = 32'h7000_0000 + $urandom_range(0, 255);
        endcase
      end
      model(rops, mres, movf);
      run0(rops, mres, movf, $sformatf("rand%0d", r), 1'b0);
    end

    // Start re-pulsed mid-run and in the FINAL cycle: a single Done.
    b0.ops = fill(32'd1, 32'd1, 32'd1);
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    dn = 0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      b0.start = (n == 9 || n == 34);
      if (b0.done) begin
        dn++;
        chk("repulse_done_cycle", 64'(n), 64'(N + 1));
      end
    end
    chk("repulse_done_count", 64'(dn), 64'd1);
    chk("repulse_result", 64'(b0.result), 64'd36);
    chk("repulse_busy_idle", 64'(b0.busy), 64'd0);

    // Start held high: back-to-back runs separated by one WAIT cycle.
    b0.ops = fill(32'd1, 32'd1, 32'd1);
    b0.start = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == N + 1) chk("b2b_wait_busy", 64'(b0.busy), 64'd0);
      if (n == N + 2) begin
        chk("b2b_restart_busy", 64'(b0.busy), 64'd1);
        b0.start = 1'b0;
      end
      if (b0.done) done_at.push_back(n);
    end
    chk("b2b_done_count", 64'(done_at.size()), 64'd2);
    if (done_at.size() == 2) begin
      chk("b2b_done1", 64'(done_at[0]), 64'(N + 1));
      chk("b2b_done2", 64'(done_at[1]), 64'(2 * N + 3));
    end
    chk("b2b_result", 64'(b0.result), 64'd36);

    // Asynchronous reset mid-run.
    run0(fill(32'd7, 32'd7, 32'd7), 32'd252, 1'b0, "pre_rst", 1'b0);
    b0.ops = fill(32'hFFFF_FFFF, 32'd2, 32'd0);
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",   64'(b0.busy),   64'd0);
    chk("midrst_done",   64'(b0.done),   64'd0);
    chk("midrst_ovf",    64'(b0.ovf),    64'd0);
    chk("midrst_result", 64'(b0.result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run0(fill(32'd1, 32'd1, 32'd1), 32'd36, 1'b0, "post_rst", 1'b0);

    // Minimal configuration: WIDTH=8, NUM_OPS=2.
    for (int v = 0; v < 2; v++) begin
      logic [W1-1:0] e_res;
      logic          e_ovf;
      @(negedge clk);
      if (v == 0) begin b1.ops = {8'd4, 8'd3};   e_res = 8'd14;                    e_ovf = 1'b0; end
      else        begin b1.ops = {8'd100, 8'd200}; e_res = SAT ? 8'd255 : 8'd88;  e_ovf = 1'b1; end
      b1.start = 1'b1;
      @(negedge clk);
      b1.start = 1'b0;
      chk($sformatf("small%0d_busy_e0", v), 64'(b1.busy), 64'd1);
      for (int n = 1; n <= 4; n++) begin
        @(negedge clk);
        if (n == 2) chk($sformatf("small%0d_result_e2", v), 64'(b1.result), 64'(e_res));
        chk($sformatf("small%0d_done_n%0d", v, n), 64'(b1.done), (n == 3) ? 64'd1 : 64'd0);
      end
      chk($sformatf("small%0d_ovf", v), 64'(b1.ovf), 64'(e_ovf));
      chk($sformatf("small%0d_busy_idle", v), 64'(b1.busy), 64'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/hlsm_chain_accum.md
HLSM_CHAIN_ACCUM -- requirements
Module: hlsm_chain_accum

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand and result width in bits (>=2).
REQ-002 Parameter NUM_OPS, default 34, SHALL set the operand count (>=2).
REQ-003 Clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 Rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 Start  input  1  SHALL request a computation; sampled only in WAIT.
REQ-006 Ops  input  NUM_OPS*WIDTH  SHALL carry the flattened operands; op[k] = Ops[k*WIDTH +: WIDTH].
REQ-007 Done  output  1  SHALL be a one-cycle completion pulse.
REQ-008 Busy  output  1  SHALL be high in every state except WAIT.
REQ-009 Ovf  output  1  SHALL be a sticky flag set when any add in the current run carries out of WIDTH bits.
REQ-010 Final  output  WIDTH  SHALL carry the result, held from write until the next write or reset.

Function
REQ-011 The FSM SHALL have the states WAIT, LOAD, ACC, FIX and FINAL, encoded in a single state register.
REQ-012 WAIT with Start=1 at edge E0 SHALL capture all NUM_OPS operands into a snapshot, clear Ovf, clear Done and go to LOAD.
REQ-013 Later Ops changes SHALL NOT affect the run.
REQ-014 LOAD (E1) SHALL compute t1 = op[0]+op[1] and set acc = t1; if NUM_OPS=2 it SHALL go to FIX, else to ACC with idx=2.
REQ-015 ACC SHALL perform acc = acc + op[idx] and idx++ once per cycle until op[NUM_OPS-1] is added, then go to FIX.
REQ-016 Edges E1..E(NUM_OPS-1) SHALL perform exactly NUM_OPS-1 adds in total.
REQ-017 FIX (edge E(NUM_OPS)) SHALL write Final = acc + t1 and go to FINAL.
REQ-018 FINAL (edge E(NUM_OPS+1)) SHALL set Done=1 and return to WAIT.
REQ-019 Done SHALL return to 0 at the next edge, giving a pulse of exactly one cycle.
REQ-020 Result SHALL equal sum(op[0..NUM_OPS-1]) + op[0] + op[1], computed modulo 2^WIDTH.
REQ-021 Ovf SHALL be the OR of the carry-outs of every add in the run, including the FIX add.
REQ-022 Start in any state other than WAIT SHALL be ignored, including the FINAL cycle.
REQ-023 Start held high SHALL produce back-to-back runs, with one WAIT cycle between runs.
REQ-024 The index counter SHALL be $clog2(NUM_OPS)+1 bits wide and SHALL NOT wrap within a run.

Reset
REQ-025 Rst low SHALL, immediately and at any time including mid-run, force state=WAIT, Done=0, Busy=0, Ovf=0, Final=0, t1=0, acc=0 and idx=0.
REQ-026 The first Start after Rst rises SHALL run normally.

Configuration
REQ-027 With macro HLSM_SATURATE_EN defined, every add SHALL clamp to 2^WIDTH-1 on carry-out instead of wrapping, and Ovf SHALL still be set.
REQ-028 Without HLSM_SATURATE_EN, every add SHALL wrap modulo 2^WIDTH.

Verification (WIDTH=32, NUM_OPS=34 unless stated)
REQ-029 All op=1, Start at E0 -> Final=36 written at E34; Done=1 only in the cycle after E35; Ovf=0; Busy high E0..E35.
REQ-030 op[0]=0xFFFFFFFF, op[1]=2, rest 0 -> Final=2 and Ovf=1 without macro; Final=0xFFFFFFFF and Ovf=1 with HLSM_SATURATE_EN.
REQ-031 Start re-pulsed at E10 and at the FINAL cycle -> exactly one Done pulse; Final=36 with the all-ones data.
REQ-032 Rst low at E15 -> Busy, Done, Ovf and Final all 0 within the same cycle; next Start gives Final=36 at the correct cycle.
REQ-033 WIDTH=8, NUM_OPS=2, op[0]=3, op[1]=4 -> Final=14 at E2; Done in the cycle after E3.
REQ-034 All op=1 at Start, then all op=5 from E1 -> Final=36, because the snapshot is used.
